// File: rtl/dsp_file_responder.sv
`default_nettype none
// ============================================================================
// dsp_file_responder : responder for the DSP equation file-access strobes,
//                      holding NUM_FILES word-addressed sample files.
// Revision 1.0
// ============================================================================
module dsp_file_responder #(
  parameter int NUM_FILES = 4,
  parameter int DEPTH     = 256,
  parameter int dw        = 32
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic [7:0]    file_num,
  input  logic          file_read,
  input  logic          file_write,
  input  logic [dw-1:0] file_write_data,
  input  logic          file_rewind,
  output logic [dw-1:0] file_read_data,
  output logic          file_active,
  output logic [31:0]   rd_ptr,
  output logic [31:0]   wr_ptr,
  output logic          eof,
  output logic          overflow,
  output logic          error
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int FW    = (NUM_FILES > 1) ? $clog2(NUM_FILES) : 1;
  localparam int NSLOT = 1 << FW;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_ADDR = 2'd1;
  localparam logic [1:0] S_RD_DATA = 2'd2;
  localparam logic [1:0] S_WR      = 2'd3;

  logic [dw-1:0] mem_q [NSLOT*DEPTH];
  logic [PW-1:0] rp_q  [NSLOT];
  logic [PW-1:0] wp_q  [NSLOT];

  logic [1:0]    state_q, state_d;
  logic [FW-1:0] fsel_q;
  logic [dw-1:0] wdata_q;
  logic [dw-1:0] rdata_q;
  logic [dw-1:0] file_read_data_q;
  logic          file_active_q;
  logic [31:0]   rd_ptr_q, wr_ptr_q;
  logic          eof_q, overflow_q, error_q;

  logic [FW-1:0]    w_idx;
  logic [PW-1:0]    w_cur_rp, w_cur_wp, w_sel_rp, w_sel_wp;
  logic             w_num_ok, w_multi, w_any, w_accept, w_legal, w_illegal;
  logic             w_empty, w_full;
  logic             w_rd_go, w_rd_eof, w_wr_go, w_wr_ovf, w_rew;
  logic [FW+AW-1:0] w_raddr, w_waddr;

  assign w_idx     = file_num[FW-1:0];
  assign w_num_ok  = ({24'd0, file_num} < 32'(NUM_FILES));
  assign w_multi   = (file_read & file_write) | (file_read & file_rewind) |
                     (file_write & file_rewind);
  assign w_any     = file_read | file_write | file_rewind;
  assign w_accept  = (state_q == S_IDLE) && w_any;
  assign w_illegal = w_accept && (w_multi || !w_num_ok);
  assign w_legal   = w_accept && !w_multi && w_num_ok;

  assign w_cur_rp  = rp_q[w_idx];
  assign w_cur_wp  = wp_q[w_idx];
  assign w_empty   = (w_cur_rp == w_cur_wp);
  assign w_full    = (w_cur_wp == PW'(DEPTH));

  assign w_rd_go   = w_legal & file_read  & ~w_empty;
  assign w_rd_eof  = w_legal & file_read  &  w_empty;
  assign w_wr_go   = w_legal & file_write & ~w_full;
  assign w_wr_ovf  = w_legal & file_write &  w_full;
  assign w_rew     = w_legal & file_rewind;

  // Pointers of the file latched at accept, used by the in-flight access.
  assign w_sel_rp  = rp_q[fsel_q];
  assign w_sel_wp  = wp_q[fsel_q];
  assign w_raddr   = {fsel_q, w_sel_rp[AW-1:0]};
  assign w_waddr   = {fsel_q, w_sel_wp[AW-1:0]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_rd_go)      state_d = S_RD_ADDR;
        else if (w_wr_go) state_d = S_WR;
      end
      S_RD_ADDR: state_d = S_RD_DATA;
      S_RD_DATA: state_d = S_IDLE;
      S_WR:      state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q          <= S_IDLE;
      file_active_q    <= 1'b0;
      eof_q            <= 1'b0;
      overflow_q       <= 1'b0;
      error_q          <= 1'b0;
      file_read_data_q <= '0;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      fsel_q           <= '0;
      wdata_q          <= '0;
      rdata_q          <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        rp_q[i] <= '0;
        wp_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      file_active_q <= (state_d != S_IDLE);
      eof_q         <= w_rd_eof;
      overflow_q    <= w_wr_ovf;
      error_q       <= w_illegal;

      if (w_rd_go || w_wr_go) begin
        fsel_q  <= w_idx;
        wdata_q <= file_write_data;
      end

      if (w_rd_eof) file_read_data_q <= '0;

      if (w_rd_eof || w_wr_ovf) begin
        rd_ptr_q <= 32'(w_cur_rp);
        wr_ptr_q <= 32'(w_cur_wp);
      end

      if (w_rew) begin
        rp_q[w_idx] <= '0;
        rd_ptr_q    <= '0;
        wr_ptr_q    <= 32'(w_cur_wp);
      end

      if (state_q == S_RD_ADDR) rdata_q <= mem_q[w_raddr];

      if (state_q == S_RD_DATA) begin
        file_read_data_q <= rdata_q;
        rp_q[fsel_q]     <= w_sel_rp + PW'(1);
        rd_ptr_q         <= 32'(w_sel_rp + PW'(1));
        wr_ptr_q         <= 32'(w_sel_wp);
      end

      if (state_q == S_WR) begin
        wp_q[fsel_q] <= w_sel_wp + PW'(1);
        wr_ptr_q     <= 32'(w_sel_wp + PW'(1));
        rd_ptr_q     <= 32'(w_sel_rp);
      end
    end
  end

  // Storage survives reset; only an access completing outside reset commits.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst && state_q == S_WR) mem_q[w_waddr] <= wdata_q;
  end

  assign file_read_data = file_read_data_q;
  assign file_active    = file_active_q;
  assign rd_ptr         = rd_ptr_q;
  assign wr_ptr         = wr_ptr_q;
  assign eof            = eof_q;
  assign overflow       = overflow_q;
  assign error          = error_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_file_responder.sv
`default_nettype none
// Bench for dsp_file_responder: randomized requests, queue-of-files reference
// model, scoreboard monitor comparing every DUT response event.
module tb_dsp_file_responder;

  localparam int NF = 4;
  localparam int DP = 4;
  localparam int K_RD  = 0;
  localparam int K_WR  = 1;
  localparam int K_EOF = 2;
  localparam int K_OVF = 3;
  localparam int K_ERR = 4;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic [7:0]  file_num = '0;
  logic        file_read = 1'b0, file_write = 1'b0, file_rewind = 1'b0;
  logic [31:0] file_write_data = '0;
  logic [31:0] file_read_data, rd_ptr, wr_ptr;
  logic        file_active, eof, overflow, error;

  dsp_file_responder #(.NUM_FILES(NF), .DEPTH(DP), .dw(32)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .file_num(file_num),
    .file_read(file_read), .file_write(file_write),
    .file_write_data(file_write_data), .file_rewind(file_rewind),
    .file_read_data(file_read_data), .file_active(file_active),
    .rd_ptr(rd_ptr), .wr_ptr(wr_ptr), .eof(eof), .overflow(overflow),
    .error(error)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct {
    int          kind;
    int          alen;
    logic [31:0] data;
    logic [31:0] rd;
    logic [31:0] wr;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: each file is a list of stored words plus a read index.
  logic [31:0] fmem [NF][DP];
  int          fcnt [NF];
  int          rdi  [NF];
  logic [31:0] m_data = '0, m_rd = '0, m_wr = '0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exv);
    checks++;
    if (act !== exv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exv, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NF; i++) begin
      fcnt[i] = 0;
      rdi[i]  = 0;
    end
    m_data = '0; m_rd = '0; m_wr = '0;
  endfunction

  // Monitor: every pulse or end of an active window is one response event.
  bit prev_act = 1'b0;
  int act_cnt  = 0;
  always @(negedge wb_clk) begin
    exp_t e;
    int   ko;
    int   ek;
    if (wb_rst) begin
      prev_act = 1'b0;
      act_cnt  = 0;
    end else begin
      if (file_active) act_cnt++;
      if (eof || overflow || error || (prev_act && !file_active)) begin
        ko = eof ? K_EOF : overflow ? K_OVF : error ? K_ERR : K_RD;
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got kind %0d expected none at %0t", ko, $time);
        end else begin
          e  = expq.pop_front();
          ek = (e.kind == K_WR) ? K_RD : e.kind;
          chk("event_kind", 32'(ko), 32'(ek));
          chk("active_cycles", 32'(act_cnt), 32'(e.alen));
          chk("read_data", file_read_data, e.data);
          chk("rd_ptr", rd_ptr, e.rd);
          chk("wr_ptr", wr_ptr, e.wr);
        end
        act_cnt = 0;
      end
      prev_act = file_active;
    end
  end

  // Issue one request from just after a rising edge; returns once a new
  // request may be accepted. poke drives a stray strobe while busy.
  task automatic do_op(input bit r, input bit w, input bit rw,
                       input logic [7:0] fn, input logic [31:0] d, input bit poke);
    exp_t e;
    int   lat;
    int   ns;
    int   f;
    bit   rew;
    lat = 0;
    rew = 1'b0;
    ns  = int'(r) + int'(w) + int'(rw);
    f   = int'(fn);
    e.alen = 0;
    if (ns > 0) begin
      if (ns > 1 || f >= NF) begin
        e.kind = K_ERR;
        e.data = m_data; e.rd = m_rd; e.wr = m_wr;
        expq.push_back(e);
      end else begin
        if (r) begin
          if (rdi[f] == fcnt[f]) begin
            e.kind = K_EOF;
            m_data = '0;
          end else begin
            e.kind = K_RD; e.alen = 2; lat = 2;
            m_data = fmem[f][rdi[f]];
            rdi[f]++;
          end
        end else if (w) begin
          if (fcnt[f] == DP) begin
            e.kind = K_OVF;
          end else begin
            e.kind = K_WR; e.alen = 1; lat = 1;
            fmem[f][fcnt[f]] = d;
            fcnt[f]++;
          end
        end else begin
          rdi[f] = 0;
          rew    = 1'b1;
        end
        m_rd = 32'(rdi[f]);
        m_wr = 32'(fcnt[f]);
        e.data = m_data; e.rd = m_rd; e.wr = m_wr;
        if (!rew) expq.push_back(e);
      end
    end
    file_read = r; file_write = w; file_rewind = rw;
    file_num = fn; file_write_data = d;
    @(posedge wb_clk); #1;
    file_read = 1'b0; file_write = 1'b0; file_rewind = 1'b0;
    if (rew) begin
      chk("rewind_rd_ptr", rd_ptr, 32'd0);
      chk("rewind_wr_ptr", wr_ptr, m_wr);
    end
    if (poke && lat > 0) begin
      file_write = 1'b1; file_read = 1'b1; file_num = 8'(($urandom_range(0, NF-1)));
      @(posedge wb_clk); #1;
      file_write = 1'b0; file_read = 1'b0;
      lat--;
    end
    repeat (lat) begin
      @(posedge wb_clk); #1;
    end
  endtask

  initial begin
    logic [31:0] fill [4];
    int          op;
    int          m;
    logic [7:0]  fn;
    logic [31:0] d;

    model_reset();
    repeat (3) @(posedge wb_clk);
    #1;
    chk("reset_read_data", file_read_data, 32'd0);
    chk("reset_active", 32'(file_active), 32'd0);
    chk("reset_rd_ptr", rd_ptr, 32'd0);
    chk("reset_wr_ptr", wr_ptr, 32'd0);
    chk("reset_pulses", {29'd0, eof, overflow, error}, 32'd0);
    wb_rst = 1'b0;

    // File 2: three writes, three reads, eof, rewind, re-read.
    do_op(0, 1, 0, 8'd2, 32'h11, 0);
    do_op(0, 1, 0, 8'd2, 32'h22, 0);
    do_op(0, 1, 0, 8'd2, 32'h33, 0);
    do_op(1, 0, 0, 8'd2, 32'h0, 0);
    do_op(1, 0, 0, 8'd2, 32'h0, 1);
    do_op(1, 0, 0, 8'd2, 32'h0, 0);
    do_op(1, 0, 0, 8'd2, 32'h0, 0);
    do_op(0, 0, 1, 8'd2, 32'h0, 0);
    do_op(1, 0, 0, 8'd2, 32'h0, 0);

    // File 0: fill to DEPTH, overflow, then read everything back.
    for (int i = 0; i < 4; i++) begin
      fill[i] = $urandom;
      do_op(0, 1, 0, 8'd0, fill[i], 0);
    end
    do_op(0, 1, 0, 8'd0, 32'hDEAD, 0);
    for (int i = 0; i < 4; i++) do_op(1, 0, 0, 8'd0, 32'h0, 0);
    do_op(1, 0, 0, 8'd0, 32'h0, 0);

    // Illegal requests.
    do_op(1, 1, 0, 8'd1, 32'h55, 0);
    do_op(1, 0, 0, 8'd7, 32'h0, 0);
    do_op(0, 1, 0, 8'd7, 32'h77, 0);

    // Reset asserted while a write to file 1 is in flight.
    file_num = 8'd1; file_write = 1'b1; file_write_data = 32'hBEEF;
    @(posedge wb_clk); #1;
    file_write = 1'b0;
    wb_rst = 1'b1;
    @(posedge wb_clk); #1;
    @(posedge wb_clk); #1;
    chk("midrst_read_data", file_read_data, 32'd0);
    chk("midrst_active", 32'(file_active), 32'd0);
    chk("midrst_rd_ptr", rd_ptr, 32'd0);
    chk("midrst_wr_ptr", wr_ptr, 32'd0);
    chk("midrst_pulses", {29'd0, eof, overflow, error}, 32'd0);
    wb_rst = 1'b0;
    model_reset();
    do_op(1, 0, 0, 8'd1, 32'h0, 0);
    do_op(1, 0, 0, 8'd2, 32'h0, 0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 11);
      fn = 8'($urandom_range(0, NF-1));
      d  = $urandom;
      case (op)
        0, 1, 2, 3: do_op(1, 0, 0, fn, d, ($urandom_range(0, 3) == 0));
        4, 5, 6, 7: do_op(0, 1, 0, fn, d, ($urandom_range(0, 3) == 0));
        8:          do_op(0, 0, 1, fn, d, 0);
        9: begin
          m = $urandom_range(0, 3);
          case (m)
            0:       do_op(1, 1, 0, fn, d, 0);
            1:       do_op(1, 0, 1, fn, d, 0);
            2:       do_op(0, 1, 1, fn, d, 0);
            default: do_op(1, 1, 1, fn, d, 0);
          endcase
        end
        10: begin
          fn = 8'($urandom_range(NF, 255));
          m  = $urandom_range(0, 2);
          do_op(m == 0, m == 1, m == 2, fn, d, 0);
        end
        default:    do_op(0, 0, 0, fn, d, 0);
      endcase
    end

    repeat (5) @(posedge wb_clk);
    #1;
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
